// File: rtl/led_pkg.sv
// ============================================================================
// led_pkg
// Shared mode encoding for the LED pattern generator and its channels.
// Revision: 1.0
// ============================================================================
`default_nettype none

package led_pkg;

  localparam int MODE_W = 2;

  // Channel operating mode as written through the configuration port
  typedef enum logic [MODE_W-1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_PWM   = 2'd2,
    MODE_BURST = 2'd3
  } mode_t;

endpackage

`default_nettype wire

// File: rtl/led_channel.sv
// ============================================================================
// led_channel
// One LED channel: holds mode/duty/burst count and produces a registered
// LED drive from the shared period counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module led_channel
  import led_pkg::*;
#(
  parameter int CNT_W        = 5,
  parameter int BURST_W      = 4,
  parameter int DEFAULT_DUTY = 16
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic [CNT_W-1:0]   i_cnt,
  input  logic               i_wrap,
  input  logic               i_wr_en,
  input  logic [MODE_W-1:0]  i_wr_mode,
  input  logic [CNT_W-1:0]   i_wr_duty,
  input  logic [BURST_W-1:0] i_wr_bursts,
  output logic               o_led,
  output logic               o_busy
);

  mode_t              mode;
  logic [CNT_W-1:0]   duty;
  logic [BURST_W-1:0] remaining;
  mode_t              wr_mode;

  assign wr_mode = mode_t'(i_wr_mode);

  // Configuration state, burst countdown and registered LED drive
  always_ff @(posedge clk) begin
    if (i_reset) begin
      mode      <= MODE_PWM;
      duty      <= CNT_W'(DEFAULT_DUTY);
      remaining <= '0;
      o_led     <= 1'b0;
    end else begin
      // LED output is computed from the state present before this edge
      case (mode)
        MODE_OFF: o_led <= 1'b0;
        MODE_ON:  o_led <= 1'b1;
        default:  o_led <= (i_cnt < duty);
      endcase

      // A write always takes priority over the wrap decrement
      if (i_wr_en) begin
        duty <= i_wr_duty;
        if (wr_mode == MODE_BURST && i_wr_bursts == '0) begin
          mode      <= MODE_OFF;
          remaining <= '0;
        end else begin
          mode      <= wr_mode;
          remaining <= i_wr_bursts;
        end
      end else if (i_wrap && mode == MODE_BURST) begin
        remaining <= remaining - BURST_W'(1);
        if (remaining == BURST_W'(1)) begin
          mode <= MODE_OFF;
        end
      end
    end
  end

  assign o_busy = (mode == MODE_BURST) && (remaining != '0);

endmodule

`default_nettype wire

// File: rtl/led_pattern_gen.sv
// ============================================================================
// led_pattern_gen
// Multi-channel LED pattern generator: shared prescaler and period counter
// feeding N_CH independently configurable OFF/ON/PWM/BURST channels.
// Revision: 1.0
// ============================================================================
`default_nettype none

module led_pattern_gen
  import led_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int CNT_W        = 5,
  parameter int PRESCALE     = 1,
  parameter int DEFAULT_DUTY = 16,
  parameter int BURST_W      = 4,
  localparam int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic               i_wr_en,
  input  logic [CH_W-1:0]    i_wr_ch,
  input  logic [MODE_W-1:0]  i_wr_mode,
  input  logic [CNT_W-1:0]   i_wr_duty,
  input  logic [BURST_W-1:0] i_wr_bursts,
  output logic [N_CH-1:0]    o_led,
  output logic [N_CH-1:0]    o_busy,
  output logic               o_period_start
);

  localparam int PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PRESC_W-1:0] presc;
  logic [CNT_W-1:0]   cnt;
  logic               tick;
  logic               wrap;

  assign tick = (presc == PRESC_W'(PRESCALE - 1));
  assign wrap = tick && (cnt == '1);

  // Prescaler, free-running period counter and wrap pulse
  always_ff @(posedge clk) begin
    if (i_reset) begin
      presc          <= '0;
      cnt            <= '0;
      o_period_start <= 1'b0;
    end else begin
      presc          <= tick ? '0 : presc + PRESC_W'(1);
      o_period_start <= wrap;
      if (tick) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // One channel per LED; out-of-range channel numbers decode to no channel
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic wr_hit;
    assign wr_hit = i_wr_en && (i_wr_ch == CH_W'(g));

    led_channel #(
      .CNT_W        (CNT_W),
      .BURST_W      (BURST_W),
      .DEFAULT_DUTY (DEFAULT_DUTY)
    ) u_ch (
      .clk         (clk),
      .i_reset     (i_reset),
      .i_cnt       (cnt),
      .i_wrap      (wrap),
      .i_wr_en     (wr_hit),
      .i_wr_mode   (i_wr_mode),
      .i_wr_duty   (i_wr_duty),
      .i_wr_bursts (i_wr_bursts),
      .o_led       (o_led[g]),
      .o_busy      (o_busy[g])
    );
  end

endmodule

`default_nettype wire
